cc_ctx_unit: RTL and testbench
==============================

Name: cc_ctx_unit

Overview:
- Parametrised condition-code and branch-enable unit for the LC-3 datapath, generalised to any datapath width.
- Holds the N/Z/P flags and a registered BEN.
- Adds a LIFO of saved condition codes for interrupt entry and RTI, plus a direct PSR-driven CC load.
- Sits beside the bus and IR and is driven by the control FSM's LD_CC, LD_BEN and save/restore strobes.

Parameters:
- DATA_W, 16, width of the bus value inspected for flags (at least 2).
- DEPTH, 4, number of saved CC contexts in the LIFO (at least 1).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- LD_CC  in  1  load flags computed from Bus_Val.
- LD_PSR_CC  in  1  load flags directly from PSR_NZP.
- PSR_NZP  in  3  explicit {N,Z,P} value for LD_PSR_CC.
- Bus_Val  in  DATA_W  value on the datapath bus.
- IR_NZP  in  3  branch condition bits, IR[11:9].
- LD_BEN  in  1  register the branch-enable decision.
- CC_Push  in  1  save the current NZP to the LIFO (interrupt entry).
- CC_Pop  in  1  restore NZP from the LIFO top (RTI).
- Err_Clr  in  1  clear the sticky Stack_Err.
- NZP  out  3  current {N,Z,P}.
- BEN_Val  out  1  registered branch enable.
- Depth  out  $clog2(DEPTH+1)  number of saved entries.
- Stack_Full  out  1  Depth == DEPTH.
- Stack_Empty  out  1  Depth == 0.
- Stack_Err  out  1  sticky overflow, underflow or conflict flag.

Behaviour:
- Clock and reset: one clock (Clk). Synchronous active-high Reset; Reset has priority over every other input.
- Reset values: NZP=000, BEN_Val=0, Depth=0, Stack_Empty=1, Stack_Full=0, Stack_Err=0. LIFO contents are don't-care.
- Flag computation (combinational):
  - Bus_Val == 0 gives 010.
  - Otherwise, Bus_Val[DATA_W-1]=1 gives 100.
  - Otherwise 001.
  - The result is always one-hot.
- NZP update priority (one update per edge): CC_Pop (valid) > LD_PSR_CC > LD_CC > hold.
  - PSR_NZP is loaded verbatim, including non-one-hot values; no check is made.
- BEN:
  - On LD_BEN, BEN_Val <= |(IR_NZP & NZP), using the NZP value registered before this edge.
  - Latency is 1 cycle; BEN_Val holds otherwise.
  - LD_CC together with LD_BEN: BEN uses the old flags.
- CC_Push alone, not full: LIFO[Depth] <= NZP (pre-update value), Depth+1.
  - Push with LD_CC or LD_PSR_CC in the same cycle saves the old NZP, and NZP takes the new value.
- CC_Push when full: LIFO and Depth unchanged, Stack_Err <= 1. The NZP load rules still apply.
- CC_Pop alone, not empty: NZP <= LIFO[Depth-1], Depth-1. Any simultaneous LD_CC or LD_PSR_CC is overridden.
- CC_Pop when empty: NZP follows the LD rules as if no pop occurred; Stack_Err <= 1; Depth stays 0.
- CC_Push and CC_Pop together: LIFO, Depth and NZP stack effects are suppressed; Stack_Err <= 1; NZP follows the LD rules.
- Stack_Err is sticky.
  - It is cleared only by Reset or Err_Clr.
  - A new error in the same cycle as Err_Clr wins, so Stack_Err = 1.
- Stack_Full and Stack_Empty are combinational decodes of Depth. Depth never exceeds DEPTH and never wraps.
- Reset asserted mid-sequence discards all saved contexts; no partial state survives.

Decomposition:
- Package cc_pkg:
  - typedef nzp_t (logic [2:0]).
  - Constants NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, NZP_NONE=3'b000.
  - Function nzp_of(value) for flag computation, width-generic via a parameterised class or let.
- Sub-module cc_lifo:
  - Parameterised DEPTH x nzp_t register stack.
  - push, pop, push_data, top, depth, full, empty, and error-pulse outputs.
  - Contains no NZP-selection logic.
- cc_ctx_unit instantiates cc_lifo and owns the NZP/BEN registers and Stack_Err.

Test Plan:
1. Reset, then LD_CC with Bus_Val=16'h8000, then 16'h0000, then 16'h0001 -> NZP=100, 010, 001 on successive cycles; BEN_Val stays 0.
2. NZP=001; LD_BEN with IR_NZP=3'b001 -> BEN_Val=1 next cycle. In the same cycle as LD_CC with Bus_Val=0, LD_BEN with IR_NZP=3'b010 -> BEN_Val=0 (old flags used).
3. NZP=100; CC_Push+LD_CC with Bus_Val=5 -> NZP=001, Depth=1. Then CC_Pop -> NZP=100, Depth=0, Stack_Empty=1.
4. With DEPTH=4: push 5 times -> Depth=4, Stack_Full=1, Stack_Err=1 after the 5th push. Then pop 4 times -> entries return in reverse order.
5. Pop when empty with LD_PSR_CC, PSR_NZP=3'b010 -> NZP=010, Stack_Err=1. Then Err_Clr -> Stack_Err=0.
6. Depth=2, then Reset for one cycle -> Depth=0, NZP=000, BEN_Val=0. Push+Pop in the same cycle -> Depth unchanged, Stack_Err=1.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and helpers for the condition-code context unit.
//   nzp_t   : {N,Z,P} flag triple
//   NZP_*   : canonical flag encodings
//   nzp_of  : flag computation from the zero and sign properties of a bus value
package cc_pkg;

    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N    = 3'b100;
    localparam nzp_t NZP_Z    = 3'b010;
    localparam nzp_t NZP_P    = 3'b001;
    localparam nzp_t NZP_NONE = 3'b000;

    // The caller reduces its value of any width to (is_zero, sign). This keeps
    // the function independent of the datapath width. The result is always one-hot.
    function automatic nzp_t nzp_of(input logic is_zero, input logic sign);
        if (is_zero) begin
            return NZP_Z;
        end else if (sign) begin
            return NZP_N;
        end else begin
            return NZP_P;
        end
    endfunction

endpackage

// File: rtl/cc_lifo.sv
// LIFO of saved condition codes.
//   Clk, Reset : clock, synchronous active-high reset (clears depth only)
//   push, pop  : stack strobes; both together is an error and does nothing
//   push_data  : value saved on a valid push
//   top        : most recent entry (NZP_NONE when empty)
//   depth      : number of valid entries, saturates at DEPTH
//   full/empty : decodes of depth
//   err        : single-cycle pulse on overflow, underflow or push+pop conflict
module cc_lifo
    import cc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         push,
    input  logic                         pop,
    input  nzp_t                         push_data,
    output nzp_t                         top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    nzp_t          mem_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign full    = (depth_q == DW'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign err     = (push & pop) | (push & full) | (pop & empty);

    assign wr_idx  = AW'(depth_q);
    assign rd_idx  = AW'(depth_q - DW'(1));
    assign top     = empty ? NZP_NONE : mem_q[rd_idx];
    assign depth   = depth_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + DW'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - DW'(1);
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge Clk) begin
        if (!Reset && do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/cc_ctx_unit.sv
// Condition-code and branch-enable unit with a saved-context LIFO.
//   Clk, Reset      : clock, synchronous active-high reset (highest priority)
//   LD_CC, Bus_Val  : load flags computed from the bus value
//   LD_PSR_CC       : load PSR_NZP verbatim (no one-hot check)
//   IR_NZP, LD_BEN  : register BEN = |(IR_NZP & NZP) using pre-edge flags
//   CC_Push/CC_Pop  : save/restore NZP (interrupt entry / RTI)
//   Err_Clr         : clear sticky Stack_Err (a same-cycle error wins)
//   NZP, BEN_Val    : current flags and registered branch enable
//   Depth, Stack_Full, Stack_Empty, Stack_Err : LIFO status
module cc_ctx_unit
    import cc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         LD_CC,
    input  logic                         LD_PSR_CC,
    input  logic [2:0]                   PSR_NZP,
    input  logic [DATA_W-1:0]            Bus_Val,
    input  logic [2:0]                   IR_NZP,
    input  logic                         LD_BEN,
    input  logic                         CC_Push,
    input  logic                         CC_Pop,
    input  logic                         Err_Clr,
    output logic [2:0]                   NZP,
    output logic                         BEN_Val,
    output logic [$clog2(DEPTH+1)-1:0]   Depth,
    output logic                         Stack_Full,
    output logic                         Stack_Empty,
    output logic                         Stack_Err
);

    nzp_t nzp_q;
    logic ben_q;
    logic err_q;
    nzp_t bus_flags;
    nzp_t lifo_top;
    logic lifo_err;
    logic pop_ok;

    assign bus_flags = nzp_of(~|Bus_Val, Bus_Val[DATA_W-1]);

    cc_lifo #(
        .DEPTH(DEPTH)
    ) u_lifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (CC_Push),
        .pop       (CC_Pop),
        .push_data (nzp_q),
        .top       (lifo_top),
        .depth     (Depth),
        .full      (Stack_Full),
        .empty     (Stack_Empty),
        .err       (lifo_err)
    );

    // A restore only takes effect when the LIFO actually pops.
    assign pop_ok = CC_Pop & ~CC_Push & ~Stack_Empty;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            nzp_q <= NZP_NONE;
            ben_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (pop_ok) begin
                nzp_q <= lifo_top;
            end else if (LD_PSR_CC) begin
                nzp_q <= PSR_NZP;
            end else if (LD_CC) begin
                nzp_q <= bus_flags;
            end

            if (LD_BEN) begin
                ben_q <= |(IR_NZP & nzp_q);
            end

            if (lifo_err) begin
                err_q <= 1'b1;
            end else if (Err_Clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign NZP       = nzp_q;
    assign BEN_Val   = ben_q;
    assign Stack_Err = err_q;

endmodule

// File: tb/tb_cc_ctx_unit.sv
// Directed bench for cc_ctx_unit (DATA_W=16, DEPTH=4).
module tb_cc_ctx_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LD_CC;
    logic        LD_PSR_CC;
    logic [2:0]  PSR_NZP;
    logic [15:0] Bus_Val;
    logic [2:0]  IR_NZP;
    logic        LD_BEN;
    logic        CC_Push;
    logic        CC_Pop;
    logic        Err_Clr;
    logic [2:0]  NZP;
    logic        BEN_Val;
    logic [2:0]  Depth;
    logic        Stack_Full;
    logic        Stack_Empty;
    logic        Stack_Err;

    int n_checks = 0;
    int n_fail   = 0;

    cc_ctx_unit #(
        .DATA_W(16),
        .DEPTH (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .LD_CC       (LD_CC),
        .LD_PSR_CC   (LD_PSR_CC),
        .PSR_NZP     (PSR_NZP),
        .Bus_Val     (Bus_Val),
        .IR_NZP      (IR_NZP),
        .LD_BEN      (LD_BEN),
        .CC_Push     (CC_Push),
        .CC_Pop      (CC_Pop),
        .Err_Clr     (Err_Clr),
        .NZP         (NZP),
        .BEN_Val     (BEN_Val),
        .Depth       (Depth),
        .Stack_Full  (Stack_Full),
        .Stack_Empty (Stack_Empty),
        .Stack_Err   (Stack_Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Reset     = 1'b0;
        LD_CC     = 1'b0;
        LD_PSR_CC = 1'b0;
        PSR_NZP   = 3'b000;
        Bus_Val   = 16'h0000;
        IR_NZP    = 3'b000;
        LD_BEN    = 1'b0;
        CC_Push   = 1'b0;
        CC_Pop    = 1'b0;
        Err_Clr   = 1'b0;
    endtask

    // Apply current inputs across one rising edge; sample 1 ns later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [2:0] psr_vals [5] = '{3'b011, 3'b101, 3'b110, 3'b111, 3'b000};
    logic [2:0] pop_vals [4] = '{3'b110, 3'b101, 3'b011, 3'b100};

    initial begin
        idle();
        Reset = 1'b1;
        step();
        idle();
        check("rst_nzp", 32'(NZP), 32'h0);
        check("rst_ben", 32'(BEN_Val), 32'h0);
        check("rst_depth", 32'(Depth), 32'h0);
        check("rst_empty", 32'(Stack_Empty), 32'h1);
        check("rst_full", 32'(Stack_Full), 32'h0);
        check("rst_err", 32'(Stack_Err), 32'h0);

        // 1: flag computation
        LD_CC = 1'b1; Bus_Val = 16'h8000; step();
        check("t1_neg", 32'(NZP), 32'h4);
        Bus_Val = 16'h0000; step();
        check("t1_zero", 32'(NZP), 32'h2);
        Bus_Val = 16'h0001; step();
        check("t1_pos", 32'(NZP), 32'h1);
        check("t1_ben", 32'(BEN_Val), 32'h0);
        idle();

        // 2: BEN, and BEN uses pre-edge flags when LD_CC coincides
        LD_BEN = 1'b1; IR_NZP = 3'b001; step();
        check("t2_ben1", 32'(BEN_Val), 32'h1);
        LD_CC = 1'b1; Bus_Val = 16'h0000; IR_NZP = 3'b010; step();
        check("t2_ben_old", 32'(BEN_Val), 32'h0);
        check("t2_nzp", 32'(NZP), 32'h2);
        idle();
        // BEN holds without LD_BEN
        IR_NZP = 3'b010; step();
        check("t2_ben_hold", 32'(BEN_Val), 32'h0);
        // LD_PSR_CC beats LD_CC
        LD_PSR_CC = 1'b1; PSR_NZP = 3'b101; LD_CC = 1'b1; Bus_Val = 16'h0000; step();
        check("t2_psr_prio", 32'(NZP), 32'h5);
        idle();

        // 3: push saves old flags, pop restores and overrides LD_CC
        LD_CC = 1'b1; Bus_Val = 16'h8000; step();
        CC_Push = 1'b1; Bus_Val = 16'h0005; step();
        check("t3_nzp_new", 32'(NZP), 32'h1);
        check("t3_depth1", 32'(Depth), 32'h1);
        idle();
        CC_Pop = 1'b1; LD_CC = 1'b1; Bus_Val = 16'h0000; step();
        check("t3_pop_nzp", 32'(NZP), 32'h4);
        check("t3_depth0", 32'(Depth), 32'h0);
        check("t3_empty", 32'(Stack_Empty), 32'h1);
        check("t3_err", 32'(Stack_Err), 32'h0);
        idle();

        // 4: fill, overflow, then drain in reverse order (NZP starts at 100)
        for (int i = 0; i < 5; i++) begin
            CC_Push = 1'b1; LD_PSR_CC = 1'b1; PSR_NZP = psr_vals[i]; step();
            check($sformatf("t4_push%0d_nzp", i), 32'(NZP), 32'(psr_vals[i]));
            check($sformatf("t4_push%0d_depth", i), 32'(Depth), (i < 4) ? i + 1 : 4);
            check($sformatf("t4_push%0d_err", i), 32'(Stack_Err), (i < 4) ? 0 : 1);
        end
        check("t4_full", 32'(Stack_Full), 32'h1);
        idle();
        for (int i = 0; i < 4; i++) begin
            CC_Pop = 1'b1; step();
            check($sformatf("t4_pop%0d_nzp", i), 32'(NZP), 32'(pop_vals[i]));
            check($sformatf("t4_pop%0d_depth", i), 32'(Depth), 3 - i);
        end
        check("t4_empty", 32'(Stack_Empty), 32'h1);
        check("t4_err_sticky", 32'(Stack_Err), 32'h1);
        idle();
        Err_Clr = 1'b1; step();
        check("t4_err_clr", 32'(Stack_Err), 32'h0);
        idle();

        // 5: underflow falls back to LD rules; new error beats Err_Clr
        CC_Pop = 1'b1; LD_PSR_CC = 1'b1; PSR_NZP = 3'b010; step();
        check("t5_nzp", 32'(NZP), 32'h2);
        check("t5_err", 32'(Stack_Err), 32'h1);
        check("t5_depth", 32'(Depth), 32'h0);
        idle();
        Err_Clr = 1'b1; step();
        check("t5_clr", 32'(Stack_Err), 32'h0);
        CC_Pop = 1'b1; step();
        check("t5_err_wins", 32'(Stack_Err), 32'h1);
        idle();
        Err_Clr = 1'b1; step();
        check("t5_clr2", 32'(Stack_Err), 32'h0);
        idle();

        // 6: reset mid-sequence, then push+pop conflict (NZP is 010 here)
        CC_Push = 1'b1; step(); step();
        check("t6_depth2", 32'(Depth), 32'h2);
        idle();
        LD_BEN = 1'b1; IR_NZP = 3'b010; step();
        check("t6_ben_set", 32'(BEN_Val), 32'h1);
        idle();
        Reset = 1'b1; CC_Push = 1'b1; LD_CC = 1'b1; Bus_Val = 16'h8000; step();
        idle();
        check("t6_rst_depth", 32'(Depth), 32'h0);
        check("t6_rst_nzp", 32'(NZP), 32'h0);
        check("t6_rst_ben", 32'(BEN_Val), 32'h0);
        check("t6_rst_empty", 32'(Stack_Empty), 32'h1);
        CC_Push = 1'b1; step();
        check("t6_depth1", 32'(Depth), 32'h1);
        CC_Pop = 1'b1; LD_CC = 1'b1; Bus_Val = 16'h8000; step();
        check("t6_conf_depth", 32'(Depth), 32'h1);
        check("t6_conf_err", 32'(Stack_Err), 32'h1);
        check("t6_conf_nzp", 32'(NZP), 32'h4);
        idle();
        CC_Pop = 1'b1; step();
        check("t6_pop_nzp", 32'(NZP), 32'h0);
        check("t6_pop_depth", 32'(Depth), 32'h0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
